// File: rtl/norm_result_collector.sv
// Collects four-lane normalization results into a vector FIFO, streams them lane-serially,
// and issues credits upstream so every in-flight vector has a reserved FIFO slot.
module norm_result_collector #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 8,
    localparam int W        = 2*DATAWIDTH+2,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW+1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_issue,
    output logic          o_issue_ok,
    input  logic          i_valid_A,
    input  logic          i_valid_B,
    input  logic          i_valid_C,
    input  logic          i_valid_D,
    input  logic [W-1:0]  i_q_A,
    input  logic [W-1:0]  i_q_B,
    input  logic [W-1:0]  i_q_C,
    input  logic [W-1:0]  i_q_D,
    output logic          o_valid,
    output logic [W-1:0]  o_data,
    output logic [1:0]    o_lane,
    output logic          o_last,
    input  logic          i_ready,
    output logic [CW-1:0] o_count,
    output logic          o_err_misalign,
    output logic          o_err_overflow
);

    logic [4*W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  in_flight;
    logic [1:0]     lane;

    logic           arrival;
    logic           aligned;
    logic           full;
    logic           xfer;
    logic           pop;
    logic           wr_en;
    logic           issue_acc;
    logic [CW:0]    committed;
    logic [4*W-1:0] head;

    assign arrival   = i_valid_A | i_valid_B | i_valid_C | i_valid_D;
    assign aligned   = i_valid_A & i_valid_B & i_valid_C & i_valid_D;
    assign full      = (count == CW'(DEPTH));
    assign xfer      = o_valid && i_ready;
    assign pop       = xfer && (lane == 2'd3);
    // A full FIFO still accepts a write when the head pops on the same edge.
    assign wr_en     = aligned && (!full || pop);

    // Credit is decoded purely from registered state so it never depends on i_issue.
    assign committed  = {1'b0, in_flight} + {1'b0, count};
    assign o_issue_ok = (committed < (CW+1)'(DEPTH));
    assign issue_acc  = i_issue && o_issue_ok;

    assign head    = mem[rd_ptr];
    assign o_valid = (count != '0);
    assign o_lane  = lane;
    assign o_last  = o_valid && (lane == 2'd3);
    assign o_count = count;

    always_comb begin
        o_data = '0;
        if (o_valid) begin
            case (lane)
                2'd0:    o_data = head[4*W-1 -: W];
                2'd1:    o_data = head[3*W-1 -: W];
                2'd2:    o_data = head[2*W-1 -: W];
                default: o_data = head[W-1   -: W];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {i_q_A, i_q_B, i_q_C, i_q_D};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            in_flight      <= '0;
            lane           <= '0;
            o_err_misalign <= 1'b0;
            o_err_overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !pop) begin
                count <= count + CW'(1);
            end else if (!wr_en && pop) begin
                count <= count - CW'(1);
            end

            if (xfer) begin
                lane <= lane + 2'd1;
            end

            // An arrival with nothing outstanding is unmatched; the counter saturates at 0.
            if (issue_acc && !arrival) begin
                in_flight <= in_flight + CW'(1);
            end else if (arrival && !issue_acc && (in_flight != '0)) begin
                in_flight <= in_flight - CW'(1);
            end

            if (arrival && (!aligned || ((in_flight == '0) && !issue_acc))) begin
                o_err_misalign <= 1'b1;
            end
            if ((i_issue && !o_issue_ok) || (aligned && full && !pop)) begin
                o_err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_norm_result_collector.sv
// Directed bench for norm_result_collector with DATAWIDTH=8, DEPTH=4.
module tb_norm_result_collector;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int W     = 2*DW+2;
    localparam int CW    = $clog2(DEPTH)+1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_issue = 1'b0;
    logic          o_issue_ok;
    logic          i_valid_A = 1'b0, i_valid_B = 1'b0, i_valid_C = 1'b0, i_valid_D = 1'b0;
    logic [W-1:0]  i_q_A = '0, i_q_B = '0, i_q_C = '0, i_q_D = '0;
    logic          o_valid;
    logic [W-1:0]  o_data;
    logic [1:0]    o_lane;
    logic          o_last;
    logic          i_ready = 1'b0;
    logic [CW-1:0] o_count;
    logic          o_err_misalign;
    logic          o_err_overflow;

    int checks   = 0;
    int failures = 0;

    norm_result_collector #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .i_issue(i_issue), .o_issue_ok(o_issue_ok),
        .i_valid_A(i_valid_A), .i_valid_B(i_valid_B), .i_valid_C(i_valid_C), .i_valid_D(i_valid_D),
        .i_q_A(i_q_A), .i_q_B(i_q_B), .i_q_C(i_q_C), .i_q_D(i_q_D),
        .o_valid(o_valid), .o_data(o_data), .o_lane(o_lane), .o_last(o_last),
        .i_ready(i_ready), .o_count(o_count),
        .o_err_misalign(o_err_misalign), .o_err_overflow(o_err_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] c, input logic [W-1:0] d);
        i_valid_A = 1'b1; i_valid_B = 1'b1; i_valid_C = 1'b1; i_valid_D = 1'b1;
        i_q_A = a; i_q_B = b; i_q_C = c; i_q_D = d;
    endtask

    task automatic clear_arr();
        i_valid_A = 1'b0; i_valid_B = 1'b0; i_valid_C = 1'b0; i_valid_D = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; i_issue = 1'b0; i_ready = 1'b0;
        clear_arr();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
        checks++; if (o_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        checks++; if (o_issue_ok !== 1'b1) begin failures++; $display("FAIL reset_issue_ok got=%0b exp=1", o_issue_ok); end
        checks++; if (o_data !== 18'h0) begin failures++; $display("FAIL reset_data got=%0h exp=0", o_data); end
        checks++; if (o_lane !== 2'd0 || o_last !== 1'b0) begin failures++; $display("FAIL reset_lane got=%0d/%0b exp=0/0", o_lane, o_last); end
        checks++; if (o_err_misalign !== 1'b0 || o_err_overflow !== 1'b0) begin failures++; $display("FAIL reset_errs got=%0b%0b exp=00", o_err_misalign, o_err_overflow); end
    endtask

    task automatic test_single();
        do_reset();
        i_ready = 1'b1;
        i_issue = 1'b1; tick(); i_issue = 1'b0;
        checks++; if (o_issue_ok !== 1'b1) begin failures++; $display("FAIL single_ok got=%0b exp=1", o_issue_ok); end
        drive_vec(18'h00099, 18'h000CC, 18'h0, 18'h0); tick(); clear_arr();
        checks++; if (o_valid !== 1'b1 || o_lane !== 2'd0 || o_data !== 18'h00099 || o_last !== 1'b0) begin failures++; $display("FAIL single_beat0 got=%0b/%0d/%0h/%0b exp=1/0/99/0", o_valid, o_lane, o_data, o_last); end
        checks++; if (o_count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", o_count); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_lane !== 2'd1 || o_data !== 18'h000CC || o_last !== 1'b0) begin failures++; $display("FAIL single_beat1 got=%0b/%0d/%0h/%0b exp=1/1/cc/0", o_valid, o_lane, o_data, o_last); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_lane !== 2'd2 || o_data !== 18'h0 || o_last !== 1'b0) begin failures++; $display("FAIL single_beat2 got=%0b/%0d/%0h/%0b exp=1/2/0/0", o_valid, o_lane, o_data, o_last); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_lane !== 2'd3 || o_data !== 18'h0 || o_last !== 1'b1) begin failures++; $display("FAIL single_beat3 got=%0b/%0d/%0h/%0b exp=1/3/0/1", o_valid, o_lane, o_data, o_last); end
        tick();
        checks++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin failures++; $display("FAIL single_drained got=%0b/%0d exp=0/0", o_valid, o_count); end
        checks++; if (o_err_misalign !== 1'b0 || o_err_overflow !== 1'b0) begin failures++; $display("FAIL single_errs got=%0b%0b exp=00", o_err_misalign, o_err_overflow); end
    endtask

    task automatic test_credit();
        int beats;
        logic [W-1:0] exp_d;
        logic [1:0] exp_l;
        do_reset();
        i_ready = 1'b1;
        i_issue = 1'b1;
        repeat (3) tick();
        checks++; if (o_issue_ok !== 1'b1) begin failures++; $display("FAIL credit_ok3 got=%0b exp=1", o_issue_ok); end
        tick();
        checks++; if (o_issue_ok !== 1'b0) begin failures++; $display("FAIL credit_ok4 got=%0b exp=0", o_issue_ok); end
        checks++; if (o_err_overflow !== 1'b0) begin failures++; $display("FAIL credit_noovf got=%0b exp=0", o_err_overflow); end
        tick(); i_issue = 1'b0;
        checks++; if (o_err_overflow !== 1'b1) begin failures++; $display("FAIL credit_ovf got=%0b exp=1", o_err_overflow); end
        checks++; if (o_issue_ok !== 1'b0) begin failures++; $display("FAIL credit_ok5 got=%0b exp=0", o_issue_ok); end
        beats = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc < 4) drive_vec(W'(cyc*256+17), W'(cyc*256+34), W'(cyc*256+51), W'(cyc*256+68));
            else clear_arr();
            tick();
            if (cyc < 4 && o_issue_ok !== 1'b0) begin
                checks++; failures++; $display("FAIL credit_held got=%0b exp=0", o_issue_ok);
            end
            if (o_valid) begin
                exp_d = W'((beats/4)*256 + ((beats%4)+1)*17);
                exp_l = 2'(beats%4);
                checks++;
                if (beats >= 16) begin failures++; $display("FAIL credit_extra_beat got=%0d exp<16", beats); end
                else if (o_data !== exp_d || o_lane !== exp_l || o_last !== (exp_l == 2'd3)) begin
                    failures++; $display("FAIL credit_beat%0d got=%0h/%0d/%0b exp=%0h/%0d/%0b", beats, o_data, o_lane, o_last, exp_d, exp_l, exp_l == 2'd3);
                end
                beats++;
            end
        end
        checks++; if (beats !== 16) begin failures++; $display("FAIL credit_beats got=%0d exp=16", beats); end
        checks++; if (o_issue_ok !== 1'b1 || o_count !== 3'd0) begin failures++; $display("FAIL credit_return got=%0b/%0d exp=1/0", o_issue_ok, o_count); end
        checks++; if (o_err_misalign !== 1'b0) begin failures++; $display("FAIL credit_mis got=%0b exp=0", o_err_misalign); end
    endtask

    task automatic test_backpressure();
        do_reset();
        i_ready = 1'b1;
        i_issue = 1'b1; tick(); i_issue = 1'b0;
        drive_vec(18'h11, 18'h22, 18'h33, 18'h44); tick(); clear_arr();
        checks++; if (o_data !== 18'h11 || o_lane !== 2'd0) begin failures++; $display("FAIL bp_beat0 got=%0h/%0d exp=11/0", o_data, o_lane); end
        tick();
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_data !== 18'h22 || o_lane !== 2'd1 || o_last !== 1'b0) begin
                failures++; $display("FAIL bp_hold%0d got=%0b/%0h/%0d/%0b exp=1/22/1/0", i, o_valid, o_data, o_lane, o_last);
            end
        end
        i_ready = 1'b1;
        tick();
        checks++; if (o_data !== 18'h33 || o_lane !== 2'd2) begin failures++; $display("FAIL bp_beat2 got=%0h/%0d exp=33/2", o_data, o_lane); end
        tick();
        checks++; if (o_data !== 18'h44 || o_lane !== 2'd3 || o_last !== 1'b1) begin failures++; $display("FAIL bp_beat3 got=%0h/%0d/%0b exp=44/3/1", o_data, o_lane, o_last); end
        tick();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%0b exp=0", o_valid); end
    endtask

    task automatic test_misalign();
        do_reset();
        i_issue = 1'b1; tick(); i_issue = 1'b0;
        i_valid_A = 1'b1; i_valid_B = 1'b1; i_q_A = 18'h5; i_q_B = 18'h6;
        tick(); clear_arr();
        checks++; if (o_valid !== 1'b0 || o_count !== 3'd0) begin failures++; $display("FAIL mis_nowrite got=%0b/%0d exp=0/0", o_valid, o_count); end
        checks++; if (o_err_misalign !== 1'b1) begin failures++; $display("FAIL mis_flag got=%0b exp=1", o_err_misalign); end
        checks++; if (o_issue_ok !== 1'b1 || o_err_overflow !== 1'b0) begin failures++; $display("FAIL mis_ok got=%0b/%0b exp=1/0", o_issue_ok, o_err_overflow); end
        i_issue = 1'b1;
        repeat (3) tick();
        checks++; if (o_issue_ok !== 1'b1) begin failures++; $display("FAIL mis_inflight3 got=%0b exp=1", o_issue_ok); end
        tick(); i_issue = 1'b0;
        checks++; if (o_issue_ok !== 1'b0) begin failures++; $display("FAIL mis_inflight4 got=%0b exp=0", o_issue_ok); end
    endtask

    task automatic test_full_pop();
        do_reset();
        i_issue = 1'b1; repeat (4) tick(); i_issue = 1'b0;
        for (int v = 0; v < 4; v++) begin
            drive_vec(W'(v*256+17), W'(v*256+34), W'(v*256+51), W'(v*256+68)); tick();
        end
        clear_arr();
        checks++; if (o_count !== 3'd4 || o_issue_ok !== 1'b0) begin failures++; $display("FAIL full_count got=%0d/%0b exp=4/0", o_count, o_issue_ok); end
        i_ready = 1'b1;
        repeat (3) tick();
        checks++; if (o_lane !== 2'd3 || o_data !== 18'h044) begin failures++; $display("FAIL full_lane3 got=%0d/%0h exp=3/44", o_lane, o_data); end
        drive_vec(18'h411, 18'h422, 18'h433, 18'h444); tick(); clear_arr(); i_ready = 1'b0;
        checks++; if (o_count !== 3'd4 || o_err_overflow !== 1'b0) begin failures++; $display("FAIL full_pop_write got=%0d/%0b exp=4/0", o_count, o_err_overflow); end
        checks++; if (o_err_misalign !== 1'b1) begin failures++; $display("FAIL full_unmatched got=%0b exp=1", o_err_misalign); end
        checks++; if (o_lane !== 2'd0 || o_data !== 18'h111) begin failures++; $display("FAIL full_head got=%0d/%0h exp=0/111", o_lane, o_data); end
        drive_vec(18'h511, 18'h522, 18'h533, 18'h544); tick(); clear_arr();
        checks++; if (o_err_overflow !== 1'b1 || o_count !== 3'd4) begin failures++; $display("FAIL full_drop got=%0b/%0d exp=1/4", o_err_overflow, o_count); end
        i_ready = 1'b1;
        repeat (12) tick();
        checks++; if (o_data !== 18'h411 || o_lane !== 2'd0 || o_count !== 3'd1) begin failures++; $display("FAIL full_tail got=%0h/%0d/%0d exp=411/0/1", o_data, o_lane, o_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_issue = 1'b1; repeat (5) tick(); i_issue = 1'b0;
        for (int v = 0; v < 3; v++) begin
            drive_vec(W'(v+1), W'(v+2), W'(v+3), W'(v+4)); tick();
        end
        clear_arr();
        checks++; if (o_count !== 3'd3 || o_err_overflow !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%0d/%0b exp=3/1", o_count, o_err_overflow); end
        #2 rst = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_count !== 3'd0 || o_issue_ok !== 1'b1) begin failures++; $display("FAIL rmid_state got=%0b/%0d/%0b exp=0/0/1", o_valid, o_count, o_issue_ok); end
        checks++; if (o_err_misalign !== 1'b0 || o_err_overflow !== 1'b0) begin failures++; $display("FAIL rmid_errs got=%0b%0b exp=00", o_err_misalign, o_err_overflow); end
        @(negedge clk); rst = 1'b1; i_ready = 1'b1;
        repeat (3) tick();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rmid_nobeat got=%0b exp=0", o_valid); end
        i_issue = 1'b1; repeat (3) tick(); i_issue = 1'b0;
        checks++; if (o_issue_ok !== 1'b1) begin failures++; $display("FAIL rmid_credits got=%0b exp=1", o_issue_ok); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_credit();
        test_backpressure();
        test_misalign();
        test_full_pop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
